// File: rtl/fpnew_divsqrt_arbiter.sv
// fpnew_divsqrt_arbiter: round-robin sharing of one divsqrt unit with per-op owner tracking, result routing and kill
module fpnew_divsqrt_arbiter #(
  parameter int NumReq       = 3,
  parameter int PayloadWidth = 140,
  parameter int ResultWidth  = 69,
  parameter int MaxInflight  = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq*PayloadWidth-1:0] req_payload_i,
  input  logic [NumReq-1:0]              req_kill_i,
  output logic                           unit_valid_o,
  input  logic                           unit_ready_i,
  output logic [PayloadWidth-1:0]        unit_payload_o,
  input  logic                           unit_out_valid_i,
  output logic                           unit_out_ready_o,
  input  logic [ResultWidth-1:0]         unit_result_i,
  output logic [NumReq-1:0]              rsp_valid_o,
  input  logic [NumReq-1:0]              rsp_ready_i,
  output logic [ResultWidth-1:0]         rsp_result_o,
  output logic                           busy_o,
  output logic                           err_o
);
  localparam int IdxW = $clog2(NumReq);
  localparam int PtrW = MaxInflight > 1 ? $clog2(MaxInflight) : 1;
  localparam int CntW = $clog2(MaxInflight + 1);
  logic [IdxW-1:0] rr_ptr, lock_idx, grant, h_owner;
  logic [IdxW-1:0] owner_q [MaxInflight];
  logic [MaxInflight-1:0] killed_q;
  logic [PtrW-1:0] rd_ptr, wr_ptr;
  logic [CntW-1:0] count;
  logic [NumReq-1:0] elig;
  logic lock_q, err_q, full, empty, h_killed, push, pop, deliver;
  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    return p == PtrW'(MaxInflight - 1) ? '0 : p + 1'b1;
  endfunction
  assign elig = req_valid_i & ~req_kill_i;
  assign full = count == CntW'(MaxInflight);
  assign empty = count == '0;
  always_comb begin
    grant = lock_idx;
    if (!(lock_q && elig[lock_idx]))
      for (int i = NumReq - 1; i >= 0; i--)
        if (elig[(int'(rr_ptr) + i) % NumReq]) grant = IdxW'((int'(rr_ptr) + i) % NumReq);
  end
  assign unit_valid_o = ~rst_i & |elig & ~full;
  assign push = unit_valid_o & unit_ready_i;
  assign req_ready_o = push ? NumReq'(1) << grant : '0;
  assign unit_payload_o = req_payload_i[PayloadWidth*grant +: PayloadWidth];
  assign h_owner = owner_q[rd_ptr];
  assign h_killed = killed_q[rd_ptr] | req_kill_i[h_owner];
  assign deliver = ~rst_i & ~empty & unit_out_valid_i & ~h_killed;
  assign rsp_valid_o = deliver ? NumReq'(1) << h_owner : '0;
  assign unit_out_ready_o = ~rst_i & ~empty & (h_killed | rsp_ready_i[h_owner]);
  assign pop = unit_out_valid_i & unit_out_ready_o;
  assign rsp_result_o = unit_result_i;
  assign busy_o = ~empty | |req_valid_i;
  assign err_o = err_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      lock_q <= 1'b0;
      lock_idx <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      killed_q <= '0;
      err_q <= 1'b0;
    end else begin
      lock_q <= unit_valid_o & ~unit_ready_i;
      lock_idx <= grant;
      err_q <= err_q | (unit_out_valid_i & empty);
      for (int i = 0; i < MaxInflight; i++) killed_q[i] <= killed_q[i] | req_kill_i[owner_q[i]];
      if (push) begin
        rr_ptr <= grant == IdxW'(NumReq - 1) ? '0 : grant + 1'b1;
        owner_q[wr_ptr] <= grant;
        killed_q[wr_ptr] <= 1'b0;
        wr_ptr <= inc(wr_ptr);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end
endmodule
